// File: rtl/text_pkg.sv
// Shared constants and helpers for the text row renderer.
//   - Glyph geometry (8x16), character ROM address width.
//   - Letter-code to ASCII mapping used to address the character ROM.
//   - Background colour class selected for non-glyph pixels.
package text_pkg;

  localparam int unsigned GlyphW   = 8;
  localparam int unsigned GlyphH   = 16;
  localparam int unsigned RomAddrW = 11;

  localparam logic [6:0] LetterOffset = 7'h40;
  localparam logic [6:0] AsciiSpace   = 7'h20;
  localparam logic [6:0] AsciiInvalid = 7'h3F;

  typedef enum logic [1:0] {
    ClsBg,
    ClsOk,
    ClsPend,
    ClsCursor
  } bg_class_e;

  // 0 -> space, 1..26 -> 'A'..'Z', anything else -> '?'.
  function automatic logic [6:0] code_to_ascii(input logic [4:0] code);
    if (code == 5'd0) begin
      return AsciiSpace;
    end else if (code <= 5'd26) begin
      return LetterOffset + {2'b00, code};
    end else begin
      return AsciiInvalid;
    end
  endfunction

endpackage

// File: rtl/ascii_rom.sv
// Character generator ROM, 8x16 glyphs, one cycle read latency.
//   clk_i  : clock
//   addr_i : {ascii[6:0], row[3:0]}
//   data_o : glyph row byte, MSB is the leftmost pixel
// Glyphs not listed read as blank rows.
module ascii_rom (
  input  logic        clk_i,
  input  logic [10:0] addr_i,
  output logic [7:0]  data_o
);

  logic [7:0] data_d;
  logic [7:0] data_q;

  always_comb begin
    data_d = 8'h00;
    case (addr_i)
      // '?' (0x3F)
      11'h3F2: data_d = 8'h7C;
      11'h3F3: data_d = 8'hC6;
      11'h3F4: data_d = 8'hC6;
      11'h3F5: data_d = 8'h0C;
      11'h3F6: data_d = 8'h18;
      11'h3F7: data_d = 8'h18;
      11'h3F8: data_d = 8'h18;
      11'h3FA: data_d = 8'h18;
      11'h3FB: data_d = 8'h18;
      // 'A' (0x41)
      11'h412: data_d = 8'h10;
      11'h413: data_d = 8'h38;
      11'h414: data_d = 8'h6C;
      11'h415: data_d = 8'hC6;
      11'h416: data_d = 8'hC6;
      11'h417: data_d = 8'hFE;
      11'h418: data_d = 8'hC6;
      11'h419: data_d = 8'hC6;
      11'h41A: data_d = 8'hC6;
      11'h41B: data_d = 8'hC6;
      default: data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/text_blink_timer.sv
// Cursor blink timer: counts frames and toggles blink_on every BLINK_FRAMES frames.
//   clk_i, rst_ni  : clock, async active-low reset
//   frame_start_i  : one-cycle pulse per frame
//   blink_on_o     : cursor visible phase (1 out of reset)
module text_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_start_i,
  output logic blink_on_o
);

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (frame_start_i) begin
      if (cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        blink_d = ~blink_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_on_o = blink_q;

endmodule

// File: rtl/text_row_renderer.sv
// Renders a row of N_CHARS letter cells at (sx_i, sy_i) with progress colouring,
// a blinking cursor and double-buffered text. Fixed two-cycle pixel latency.
//   frame_start_i, load_i, text_i : frame pulse, text load strobe, packed 5-bit codes
//   correct_i, total_i, cursor_en_i : progress and cursor control
//   valid_i, vgax_i, vgay_i, sx_i, sy_i : pixel position and row origin
//   *_color_i : colour inputs
//   pixel_valid_o, pixel_o : valid_i delayed by 2, rendered colour (0 outside the row)
module text_row_renderer
  import text_pkg::*;
#(
  parameter int unsigned N_CHARS      = 25,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned COLOR_W      = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 frame_start_i,
  input  logic                 load_i,
  input  logic [N_CHARS*5-1:0] text_i,
  input  logic [6:0]           correct_i,
  input  logic [6:0]           total_i,
  input  logic                 cursor_en_i,
  input  logic                 valid_i,
  input  logic [9:0]           vgax_i,
  input  logic [9:0]           vgay_i,
  input  logic [9:0]           sx_i,
  input  logic [9:0]           sy_i,
  input  logic [COLOR_W-1:0]   font_color_i,
  input  logic [COLOR_W-1:0]   bg_color_i,
  input  logic [COLOR_W-1:0]   ok_color_i,
  input  logic [COLOR_W-1:0]   pend_color_i,
  output logic                 pixel_valid_o,
  output logic [COLOR_W-1:0]   pixel_o
);

  localparam int unsigned TextW = N_CHARS * 5;

  // Text double buffer
  logic [TextW-1:0] active_q, active_d, shadow_q, shadow_d;
  logic             pending_q, pending_d;

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (load_i && frame_start_i) begin
      // Frame boundary coincides with the load: show the new text immediately.
      active_d  = text_i;
      pending_d = 1'b0;
    end else if (load_i) begin
      shadow_d  = text_i;
      pending_d = 1'b1;
    end else if (frame_start_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  logic blink_on;

  text_blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .frame_start_i(frame_start_i),
    .blink_on_o   (blink_on)
  );

  // Stage 0: geometry, 11-bit compares so the box never wraps past x/y = 1023.
  logic [10:0] x_ext, y_ext, sx_ext, sy_ext;
  logic        in_box;
  logic [9:0]  dx;
  logic [6:0]  col;
  logic [2:0]  bit_idx;
  logic [3:0]  glyph_row;

  assign x_ext  = {1'b0, vgax_i};
  assign y_ext  = {1'b0, vgay_i};
  assign sx_ext = {1'b0, sx_i};
  assign sy_ext = {1'b0, sy_i};

  assign in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + 11'(GlyphW * N_CHARS)) &&
                  (y_ext >= sy_ext) && (y_ext < sy_ext + 11'(GlyphH));

  assign dx        = vgax_i - sx_i;
  assign col       = dx[9:3];
  assign bit_idx   = dx[2:0];
  assign glyph_row = 4'(vgay_i - sy_i);

  logic [4:0] cell_code;

  always_comb begin
    cell_code = '0;
    for (int unsigned i = 0; i < N_CHARS; i++) begin
      if (col == 7'(i)) begin
        cell_code = active_q[5*i +: 5];
      end
    end
  end

  logic [RomAddrW-1:0] rom_addr;
  logic [7:0]          rom_data;

  assign rom_addr = {code_to_ascii(cell_code), glyph_row};

  ascii_rom u_rom (
    .clk_i (clk_i),
    .addr_i(rom_addr),
    .data_o(rom_data)
  );

  bg_class_e          bg_class;
  logic [COLOR_W-1:0] bg_sel;

  always_comb begin
    if (cursor_en_i && (col == correct_i) && (correct_i < 7'(N_CHARS)) && blink_on) begin
      bg_class = ClsCursor;
    end else if (col < correct_i) begin
      bg_class = ClsOk;
    end else if (col < total_i) begin
      bg_class = ClsPend;
    end else begin
      bg_class = ClsBg;
    end
  end

  always_comb begin
    bg_sel = bg_color_i;
    unique case (bg_class)
      ClsCursor: bg_sel = ~bg_color_i;
      ClsOk:     bg_sel = ok_color_i;
      ClsPend:   bg_sel = pend_color_i;
      ClsBg:     bg_sel = bg_color_i;
      default:   bg_sel = bg_color_i;
    endcase
  end

  // Stage 1 (aligned with ROM data) and stage 2 (output) registers.
  logic               s1_box_q, s1_valid_q;
  logic [2:0]         s1_bit_q;
  logic [COLOR_W-1:0] s1_bg_q, s1_font_q;
  logic [COLOR_W-1:0] pixel_q, pixel_d;
  logic               pixel_valid_q;

  always_comb begin
    pixel_d = '0;
    if (s1_box_q) begin
      pixel_d = rom_data[3'd7 - s1_bit_q] ? s1_font_q : s1_bg_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q      <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      s1_box_q      <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_bit_q      <= '0;
      s1_bg_q       <= '0;
      s1_font_q     <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      s1_box_q      <= in_box && valid_i;
      s1_valid_q    <= valid_i;
      s1_bit_q      <= bit_idx;
      s1_bg_q       <= bg_sel;
      s1_font_q     <= font_color_i;
      pixel_q       <= pixel_d;
      pixel_valid_q <= s1_valid_q;
    end
  end

  assign pixel_o       = pixel_q;
  assign pixel_valid_o = pixel_valid_q;

endmodule

// File: tb/tb_text_row_renderer.sv
// Directed self-checking bench for text_row_renderer (N_CHARS=25, BLINK_FRAMES=2).
module tb_text_row_renderer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start, load, cursor_en, valid;
  logic [124:0] text_in;
  logic [6:0]   correct, total;
  logic [9:0]   vgax, vgay, sx, sy;
  logic [2:0]   font_color, bg_color, ok_color, pend_color;
  logic         pixel_valid;
  logic [2:0]   pixel;

  int checks = 0;
  int errors = 0;

  logic [7:0] glyph_a [16];
  logic [7:0] glyph_q [16];

  always #5 clk = ~clk;

  text_row_renderer #(
    .N_CHARS     (25),
    .BLINK_FRAMES(2),
    .COLOR_W     (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .frame_start_i(frame_start),
    .load_i       (load),
    .text_i       (text_in),
    .correct_i    (correct),
    .total_i      (total),
    .cursor_en_i  (cursor_en),
    .valid_i      (valid),
    .vgax_i       (vgax),
    .vgay_i       (vgay),
    .sx_i         (sx),
    .sy_i         (sy),
    .font_color_i (font_color),
    .bg_color_i   (bg_color),
    .ok_color_i   (ok_color),
    .pend_color_i (pend_color),
    .pixel_valid_o(pixel_valid),
    .pixel_o      (pixel)
  );

  // Drive a coordinate and return the pixel it produces two cycles later.
  task automatic get_px(input int x, input int y, output logic [2:0] p, output logic pv);
    @(negedge clk);
    vgax = 10'(x);
    vgay = 10'(y);
    @(negedge clk);
    @(negedge clk);
    p  = pixel;
    pv = pixel_valid;
  endtask

  task automatic load_text(input logic [124:0] t);
    @(negedge clk);
    load    = 1'b1;
    text_in = t;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic frame_pulse();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic load_with_frame(input logic [124:0] t);
    @(negedge clk);
    load        = 1'b1;
    frame_start = 1'b1;
    text_in     = t;
    @(negedge clk);
    load        = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [124:0] t;
    logic [2:0]   p;
    logic         pv;
    t = '0;
    t[4:0] = 5'd1;
    load_text(t);
    frame_pulse();
    get_px(102, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL reset_pre_glyph: pixel=%0d expected 7", p);
    end
    // Assert reset between clock edges while still rendering an in-box pixel.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pixel !== 3'd0) begin
      errors++;
      $display("FAIL reset_async_pixel: pixel=%0d expected 0", pixel);
    end
    checks++;
    if (pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_valid: pixel_valid=%0b expected 0", pixel_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    get_px(102, 53, p, pv);
    checks++;
    if (p !== 3'd1) begin
      errors++;
      $display("FAIL reset_text_cleared: pixel=%0d expected 1", p);
    end
    checks++;
    if (pv !== 1'b1) begin
      errors++;
      $display("FAIL reset_pixel_valid: pixel_valid=%0b expected 1", pv);
    end
    get_px(299, 65, p, pv);
    checks++;
    if (p !== 3'd1) begin
      errors++;
      $display("FAIL reset_last_cell: pixel=%0d expected 1", p);
    end
  endtask

  // Back-to-back sweep of cell 0: each output is checked exactly two cycles after its input.
  task automatic test_glyph_a();
    logic [124:0] t;
    logic [2:0]   expv [128];
    logic [7:0]   row_bits;
    t = '0;
    t[4:0] = 5'd1;
    load_text(t);
    frame_pulse();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (pixel !== expv[i-2]) begin
          errors++;
          $display("FAIL glyph_a row %0d bit %0d: pixel=%0d expected %0d",
                   (i - 2) / 8, (i - 2) % 8, pixel, expv[i-2]);
        end
      end
      if (i < 128) begin
        vgax     = 10'(100 + i % 8);
        vgay     = 10'(50 + i / 8);
        row_bits = glyph_a[i/8];
        expv[i]  = row_bits[7 - (i % 8)] ? 3'd7 : 3'd1;
      end
    end
  endtask

  task automatic test_invalid_code();
    logic [124:0] t;
    logic [7:0]   row_bits;
    logic [2:0]   p, e;
    logic         pv;
    t = '0;
    t[4:0]   = 5'd1;
    t[19:15] = 5'd27;
    load_with_frame(t);
    for (int r = 0; r < 16; r++) begin
      row_bits = glyph_q[r];
      for (int b = 0; b < 8; b++) begin
        get_px(124 + b, 50 + r, p, pv);
        e = row_bits[7 - b] ? 3'd7 : 3'd1;
        checks++;
        if (p !== e) begin
          errors++;
          $display("FAIL invalid_code row %0d bit %0d: pixel=%0d expected %0d", r, b, p, e);
        end
      end
    end
    for (int b = 0; b < 8; b++) begin
      get_px(132 + b, 53, p, pv);
      checks++;
      if (p !== 3'd1) begin
        errors++;
        $display("FAIL blank_cell bit %0d: pixel=%0d expected 1", b, p);
      end
    end
  endtask

  task automatic test_progress();
    logic [2:0] expc [7];
    logic [2:0] p;
    logic       pv;
    expc = '{3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd1, 3'd1};
    load_with_frame('0);
    correct   = 7'd2;
    total     = 7'd5;
    cursor_en = 1'b0;
    for (int c = 0; c < 7; c++) begin
      get_px(100 + 8 * c + 4, 58, p, pv);
      checks++;
      if (p !== expc[c]) begin
        errors++;
        $display("FAIL progress col %0d: pixel=%0d expected %0d", c, p, expc[c]);
      end
    end
    get_px(100 + 8 * 24, 58, p, pv);
    checks++;
    if (p !== 3'd1) begin
      errors++;
      $display("FAIL progress col 24: pixel=%0d expected 1", p);
    end
    // correct above total: ok colour wins.
    correct = 7'd4;
    total   = 7'd1;
    get_px(100 + 8 * 3 + 1, 58, p, pv);
    checks++;
    if (p !== 3'd2) begin
      errors++;
      $display("FAIL progress correct_gt_total: pixel=%0d expected 2", p);
    end
  endtask

  task automatic test_cursor();
    logic [2:0] p, e;
    logic       pv;
    do_reset();
    cursor_en = 1'b1;
    correct   = 7'd4;
    total     = 7'd6;
    // Blink: on for frames 0,1, off for 2,3, on again for 4,5.
    for (int f = 0; f < 6; f++) begin
      get_px(100 + 32 + 4, 58, p, pv);
      e = ((f % 4) < 2) ? 3'd6 : 3'd4;
      checks++;
      if (p !== e) begin
        errors++;
        $display("FAIL cursor frame %0d: pixel=%0d expected %0d", f, p, e);
      end
      frame_pulse();
    end
    get_px(100 + 24 + 4, 58, p, pv);
    checks++;
    if (p !== 3'd2) begin
      errors++;
      $display("FAIL cursor neighbour: pixel=%0d expected 2", p);
    end
    frame_pulse();
    frame_pulse();
    // Frame 8: blink on. Counter keeps running while the cursor is disabled.
    cursor_en = 1'b0;
    get_px(100 + 32 + 4, 58, p, pv);
    checks++;
    if (p !== 3'd4) begin
      errors++;
      $display("FAIL cursor disabled: pixel=%0d expected 4", p);
    end
    cursor_en = 1'b1;
    get_px(100 + 32 + 4, 58, p, pv);
    checks++;
    if (p !== 3'd6) begin
      errors++;
      $display("FAIL cursor frame 8: pixel=%0d expected 6", p);
    end
    correct = 7'd25;
    total   = 7'd25;
    get_px(100 + 8 * 24 + 4, 58, p, pv);
    checks++;
    if (p !== 3'd2) begin
      errors++;
      $display("FAIL cursor full_row: pixel=%0d expected 2", p);
    end
    get_px(300, 58, p, pv);
    checks++;
    if (p !== 3'd0) begin
      errors++;
      $display("FAIL cursor past_row: pixel=%0d expected 0", p);
    end
    cursor_en = 1'b0;
    correct   = 7'd0;
    total     = 7'd0;
  endtask

  task automatic test_buffering();
    logic [124:0] t_a, t_q;
    logic [2:0]   p;
    logic         pv;
    t_a = '0;
    t_a[4:0] = 5'd1;
    t_q = '0;
    t_q[4:0] = 5'd27;
    load_text(t_a);
    get_px(102, 53, p, pv);
    checks++;
    if (p !== 3'd1) begin
      errors++;
      $display("FAIL buffer_midframe: pixel=%0d expected 1", p);
    end
    frame_pulse();
    get_px(102, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL buffer_commit: pixel=%0d expected 7", p);
    end
    load_text('0);
    get_px(102, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL buffer_hold_old: pixel=%0d expected 7", p);
    end
    // Same-cycle load overrides the pending spaces and clears pending.
    load_with_frame(t_q);
    get_px(100, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL buffer_same_cycle: pixel=%0d expected 7", p);
    end
    frame_pulse();
    get_px(100, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL buffer_pending_cleared: pixel=%0d expected 7", p);
    end
  endtask

  task automatic test_boundary();
    int         xs [6];
    int         ys [6];
    logic [2:0] es [6];
    logic [2:0] p;
    logic       pv;
    xs = '{99, 300, 299, 150, 150, 150};
    ys = '{53, 53, 53, 49, 66, 65};
    es = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
    for (int k = 0; k < 6; k++) begin
      get_px(xs[k], ys[k], p, pv);
      checks++;
      if (p !== es[k]) begin
        errors++;
        $display("FAIL boundary (%0d,%0d): pixel=%0d expected %0d", xs[k], ys[k], p, es[k]);
      end
    end
    valid = 1'b0;
    get_px(150, 58, p, pv);
    checks++;
    if (p !== 3'd0 || pv !== 1'b0) begin
      errors++;
      $display("FAIL boundary_invalid: pixel=%0d valid=%0b expected 0/0", p, pv);
    end
    valid = 1'b1;
    // Row origin near the right edge: x=3 must not alias into the box.
    sx = 10'd1020;
    get_px(3, 53, p, pv);
    checks++;
    if (p !== 3'd0) begin
      errors++;
      $display("FAIL boundary_no_wrap: pixel=%0d expected 0", p);
    end
    get_px(1020, 53, p, pv);
    checks++;
    if (p !== 3'd7) begin
      errors++;
      $display("FAIL boundary_far_origin: pixel=%0d expected 7", p);
    end
    sx = 10'd100;
  endtask

  initial begin
    glyph_a = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    glyph_q = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'h0C, 8'h18, 8'h18,
                8'h18, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n       = 1'b0;
    frame_start = 1'b0;
    load        = 1'b0;
    text_in     = '0;
    correct     = 7'd0;
    total       = 7'd0;
    cursor_en   = 1'b0;
    valid       = 1'b1;
    vgax        = 10'd0;
    vgay        = 10'd0;
    sx          = 10'd100;
    sy          = 10'd50;
    font_color  = 3'd7;
    bg_color    = 3'd1;
    ok_color    = 3'd2;
    pend_color  = 3'd4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_glyph_a();
    test_invalid_code();
    test_progress();
    test_cursor();
    test_buffering();
    test_boundary();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_row_renderer.md
Name: text_row_renderer

Overview:
- Parametrised, pipelined successor to the single-line character display blocks.
- Renders a row of N_CHARS 5-bit letter codes (8x16 glyphs from the shared ascii_rom) at a programmable screen origin.
- Adds per-cell progress colouring, a blinking cursor, and tear-free double-buffered text loading.
- Pixel output is registered and pipeline-aligned to the ROM read latency; it sits between game logic and the VGA colour mux.

Parameters:
- N_CHARS, 25, number of character cells in the row (1..64)
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1)
- COLOR_W, 3, pixel colour width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge)
- load  in  1  strobe: capture text_in into the shadow buffer
- text_in  in  N_CHARS*5  cell i = text_in[5i+:5]; 0=space, 1..26=A..Z, 27..31=invalid
- correct  in  7  number of leading cells typed correctly
- total  in  7  number of cells typed so far
- cursor_en  in  1  enables the blinking cursor
- valid  in  1  VGA active-video flag
- vgax, vgay  in  10 each  current pixel coordinate
- sx, sy  in  10 each  top-left corner of the row
- font_color, bg_color, ok_color, pend_color  in  COLOR_W each  colour inputs
- pixel_valid  out  1  valid delayed by 2 cycles
- pixel  out  COLOR_W  rendered colour; 0 outside the row box

Behaviour:
- Reset (async, rst_n=0): active and shadow text cleared to all-zero (spaces); pending flag=0; blink counter=0; blink_on=1; all pipeline registers=0; pixel=0; pixel_valid=0.
- Geometry:
  - box is sx<=vgax<sx+8*N_CHARS and sy<=vgay<sy+16, evaluated with 11-bit compares so no wrap.
  - dx=vgax-sx, dy=vgay-sy.
  - col=dx>>3, glyph bit=dx[2:0] (bit 7-dx[2:0] of the ROM byte), glyph row=dy[3:0].
- Code mapping: 0->0x20, 1..26->code+0x40, 27..31->0x3F ('?').
- Pipeline, fixed latency 2:
  - Cycle t: ROM address {ascii, row} driven from the inputs.
  - Cycle t+1: ROM data is available; box, bit, col and colour class are registered alongside it.
  - Cycle t+2: pixel and pixel_valid are registered.
  - Every input sampled at t affects only output t+2. Back-to-back pixels are supported every cycle.
- Colour priority (in box, valid=1), evaluated on the pipelined col:
  - glyph bit=1 -> font_color
  - else cursor_en && col==correct && correct<N_CHARS && blink_on -> ~bg_color
  - else col<correct -> ok_color
  - else col<total -> pend_color
  - else bg_color
  - Out of box or valid=0 -> 0.
  - correct>total is legal; the ok_color rule wins.
- Text buffering:
  - load copies text_in to shadow and sets pending.
  - On frame_start with pending=1, shadow goes to active and pending clears.
  - load and frame_start in the same cycle: text_in goes directly to active and pending=0.
  - Rendering uses only active text; mid-frame loads never change the visible frame.
- Blink:
  - On frame_start, counter increments.
  - When counter==BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - cursor_en=0 does not stop the counter.
- Coordinates, colours, correct and total are sampled per cycle; they are not buffered.

Decomposition:
- Shared package text_pkg: glyph width 8 and height 16, ROM address width 11, the letter-to-ASCII offset 0x40, the space 0x20 and invalid 0x3F constants, and the code-to-ASCII function.
- Sub-module text_blink_timer: frame counter plus blink_on flag.
- The existing ascii_rom is instantiated unchanged, once.

Test Plan:
- Reset mid-frame with valid=1 inside the box -> pixel=0 and pixel_valid=0 immediately. After release, an all-space row renders bg_color=3'd1 for every in-box pixel.
- text_in cell0=1 ('A'), sx=100, sy=50; sweep row dy=0..15 -> pixel matches the 'A' glyph bitmap with font_color=7, exactly 2 cycles after each coordinate.
- Code 27 in cell 3 -> the glyph for '?' is rendered in x 124..131. Code 0 -> a blank cell.
- correct=2, total=5, cursor_en=0 -> background pixels are ok_color in cols 0-1, pend_color in cols 2-4, and bg_color in col 5 and beyond.
- cursor_en=1, correct=4, BLINK_FRAMES=2 -> col 4 background is ~bg_color for 2 frames, then bg_color/pend_color for 2 frames, and so on. With correct=N_CHARS, no cursor appears.
- load at mid-frame -> the old text is shown until the next frame_start. load coinciding with frame_start -> the new text appears in that frame. vgax=sx-1 and sx+8*N_CHARS -> pixel=0.
